// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_pkg                                                  |
// | Purpose  : Shared types and constants for the data-memory port       |
// |            arbiter: arbiter state encoding, return-tag owner codes   |
// |            and a helper that flags an active access.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package dmem_pkg;

  // Arbiter states: normal arbitration, draining for halt, halted.
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } arb_state_t;

  // Owner bit carried alongside each in-flight read.
  localparam logic OWN_PIPE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  // A request is an access when it reads or writes at least one byte.
  function automatic logic is_access(input logic re, input logic [3:0] we);
    return re | (|we);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ret_tag.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_ret_tag                                              |
// | Purpose  : DEPTH-deep {valid, owner} shift register that follows     |
// |            each memory read until its data returns.                  |
// | Ports    : clk, rst_n (async active-low), clk_en (hold when low)     |
// |            in_valid/in_owner   - tag pushed into entry 0             |
// |            out_valid/out_owner - tag at the tail (data returns now)  |
// |            any_valid           - a read is still outstanding beyond  |
// |                                  the one returning this cycle        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_ret_tag #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner,
  output logic any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] owner_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
          owner_q <= '0;
        end else if (clk_en) begin
          valid_q <= in_valid;
          owner_q <= in_owner;
        end
      end
      // The only entry is the tail, so nothing is left over after it.
      assign any_valid = 1'b0;
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
          owner_q <= '0;
        end else if (clk_en) begin
          valid_q <= {valid_q[DEPTH-2:0], in_valid};
          owner_q <= {owner_q[DEPTH-2:0], in_owner};
        end
      end
      // The tail entry is consumed this cycle; only earlier stages keep
      // the port busy afterwards, which lets a drain finish on the cycle
      // its last read returns.
      assign any_valid = |valid_q[DEPTH-2:0];
    end
  endgenerate

  assign out_valid = valid_q[DEPTH-1];
  assign out_owner = owner_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_port_arbiter                                         |
// | Purpose  : Shares one data-memory port between the pipeline and a    |
// |            single-beat secondary requester (DMA/debug), routes read  |
// |            data back to its owner after MEM_LAT cycles, bounds the   |
// |            secondary wait by stalling the pipeline, and drains then  |
// |            hands the port to the secondary requester on halt.        |
// | Ports    : clk, rst_n, clk_en, halt                                  |
// |            pipe_re/we/addr/wdata in, pipe_stall/pipe_rvalid out      |
// |            dma_req/we/addr/wdata in, dma_gnt/dma_rvalid out          |
// |            mem_re/we/addr/wdata out, mem_rdata in (passed through)   |
// |            halted out                                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        pipe_re,
  input  logic [3:0]  pipe_we,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  output logic        pipe_rvalid,
  input  logic        dma_req,
  input  logic [3:0]  dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic        mem_re,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        halted
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] starve_cnt;

  logic pipe_act;
  logic dma_rd;
  logic dma_sel;
  logic pipe_sel;
  logic stall_req;
  logic live;
  logic tag_valid;
  logic tag_owner;
  logic tag_pending;
  logic cnt_clear;

  assign pipe_act = is_access(pipe_re, pipe_we);
  assign dma_rd   = ~|dma_we;

  // Strobes only go out of an enabled cycle outside reset; this also keeps
  // every combinational output at zero while rst_n is held low.
  assign live = clk_en & rst_n;

  // Arbitration and next state.
  always_comb begin
    state_nxt = state;
    dma_sel   = 1'b0;
    pipe_sel  = 1'b0;
    stall_req = 1'b0;
    case (state)
      S_RUN: begin
        if (halt) begin
          // Pipeline is cut off immediately; a waiting DMA still gets in.
          dma_sel   = dma_req;
          state_nxt = S_DRAIN;
        end else begin
          dma_sel   = dma_req & (~pipe_act | (starve_cnt == CNT_MAX));
          pipe_sel  = ~dma_sel;
          stall_req = pipe_act & dma_sel;
        end
      end
      S_DRAIN: begin
        if (!tag_pending) begin
          state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        dma_sel = dma_req;
        if (!halt) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  // Port mux.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (rst_n) begin
      if (dma_sel) begin
        mem_re    = live & dma_rd;
        mem_we    = live ? dma_we : 4'h0;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end else if (pipe_sel) begin
        mem_re    = live & pipe_re;
        mem_we    = live ? pipe_we : 4'h0;
        mem_addr  = pipe_addr;
        mem_wdata = pipe_wdata;
      end
    end
  end

  assign dma_gnt    = dma_sel & live;
  assign pipe_stall = stall_req & live;
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // Starvation counter only advances during normal arbitration; any grant,
  // a dropped request or leaving normal arbitration restarts the wait.
  assign cnt_clear = dma_sel | ~dma_req | (state != S_RUN) | halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (clk_en) begin
      if (cnt_clear) begin
        starve_cnt <= '0;
      end else if (pipe_act && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  dmem_ret_tag #(
    .DEPTH(MEM_LAT)
  ) u_ret_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .in_valid (mem_re),
    .in_owner (dma_sel),
    .out_valid(tag_valid),
    .out_owner(tag_owner),
    .any_valid(tag_pending)
  );

  assign pipe_rvalid = tag_valid & (tag_owner == OWN_PIPE);
  assign dma_rvalid  = tag_valid & (tag_owner == OWN_DMA);

  // Read data is shared; the rvalid pair says whose it is.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dmem_port_arbiter                                      |
// | Purpose  : Self-checking bench for dmem_port_arbiter: directed       |
// |            scenarios plus randomized traffic against a queue-based   |
// |            reference model of ownership, starvation and halt.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_dmem_port_arbiter;

  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        halt = 1'b0;
  logic        pipe_re = 1'b0;
  logic [3:0]  pipe_we = 4'h0;
  logic [31:0] pipe_addr = 32'h0;
  logic [31:0] pipe_wdata = 32'h0;
  logic        pipe_stall;
  logic        pipe_rvalid;
  logic        dma_req = 1'b0;
  logic [3:0]  dma_we = 4'h0;
  logic [31:0] dma_addr = 32'h0;
  logic [31:0] dma_wdata = 32'h0;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        halted;

  dmem_port_arbiter #(
    .MEM_LAT     (MEM_LAT),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .halt       (halt),
    .pipe_re    (pipe_re),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_stall (pipe_stall),
    .pipe_rvalid(pipe_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 = arbitrating, 1 = draining, 2 = halted.
  // Each outstanding read is kept with the number of enabled cycles left
  // until its data is on mem_rdata.
  int   mode     = 0;
  int   wait_cnt = 0;
  int   pend_left[$];
  bit   pend_own[$];
  logic m_dsel, m_re, m_pact;
  logic [73:0] exp_v, obs_v;

  always @(negedge clk) mem_rdata <= $urandom;

  function automatic logic [73:0] outs();
    return {pipe_stall, pipe_rvalid, dma_gnt, dma_rvalid, mem_re, mem_we,
            mem_addr, mem_wdata, halted};
  endfunction

  // Mid-cycle: compute what the outputs must be, then sample the DUT.
  task automatic predict();
    logic       psel, prv, drv, e_stall;
    logic [3:0] e_we;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    m_pact = pipe_re | (|pipe_we);
    m_dsel = 1'b0;
    psel   = 1'b0;
    m_re   = 1'b0;
    if (!rst_n) begin
      exp_v = '0;
    end else begin
      case (mode)
        0: begin
          if (halt) m_dsel = dma_req;
          else begin
            m_dsel = dma_req && (!m_pact || wait_cnt >= STARVE_LIMIT);
            psel   = !m_dsel;
          end
        end
        2: m_dsel = dma_req;
        default: ;
      endcase
      e_stall = clk_en && mode == 0 && !halt && m_pact && m_dsel;
      m_re    = clk_en && (m_dsel ? (dma_we == 4'h0) : (psel && pipe_re));
      e_we    = !clk_en ? 4'h0 : m_dsel ? dma_we : psel ? pipe_we : 4'h0;
      e_addr  = m_dsel ? dma_addr : psel ? pipe_addr : 32'h0;
      e_wdata = m_dsel ? dma_wdata : psel ? pipe_wdata : 32'h0;
      prv = 1'b0;
      drv = 1'b0;
      foreach (pend_left[i]) begin
        if (pend_left[i] == 0) begin
          if (pend_own[i]) drv = 1'b1;
          else prv = 1'b1;
        end
      end
      exp_v = {e_stall, prv, (m_dsel && clk_en), drv, m_re, e_we, e_addr,
               e_wdata, (mode == 2)};
    end
    obs_v = outs();
  endtask

  // Clock edge: advance the model with the inputs of the cycle just ended.
  task automatic commit();
    int nl[$];
    bit no[$];
    bit more;
    @(posedge clk);
    if (!rst_n) begin
      pend_left.delete();
      pend_own.delete();
      mode     = 0;
      wait_cnt = 0;
    end else if (clk_en) begin
      more = 1'b0;
      foreach (pend_left[i]) begin
        if (pend_left[i] > 0) begin
          nl.push_back(pend_left[i] - 1);
          no.push_back(pend_own[i]);
          more = 1'b1;
        end
      end
      if (m_re) begin
        nl.push_back(MEM_LAT - 1);
        no.push_back(m_dsel);
      end
      pend_left = nl;
      pend_own  = no;
      if (m_dsel || !dma_req || mode != 0 || halt) wait_cnt = 0;
      else if (m_pact && wait_cnt < STARVE_LIMIT) wait_cnt++;
      case (mode)
        0: if (halt) mode = 1;
        1: if (!more) mode = 2;
        2: if (!halt) mode = 0;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic idle_inputs();
    pipe_re = 0; pipe_we = 0; pipe_addr = 0; pipe_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    halt = 0; clk_en = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; pipe_re = 1; pipe_addr = 32'h100; dma_req = 1; dma_we = 4'hF;
    for (int c = 0; c < 2; c++) begin
      predict();
      n_checks++;
      if (obs_v !== 74'h0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: got %h want 0", c, obs_v);
      end
      commit();
    end
    rst_n = 1;
    idle_inputs();
    predict();
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL reset_idle: got %h want %h", obs_v, exp_v);
    end
    commit();
  endtask

  task automatic test_pipe_read();
    idle_inputs(); pipe_re = 1; pipe_addr = 32'h100;
    for (int c = 0; c < 4; c++) begin
      predict();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL pipe_read_model c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (c == 0) begin
        n_checks++;
        if (mem_re !== 1'b1 || mem_addr !== 32'h100) begin
          n_fail++; $display("FAIL pipe_read_issue: re=%b addr=%h want re=1 addr=100", mem_re, mem_addr);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (pipe_rvalid !== 1'b1 || dma_rvalid !== 1'b0) begin
          n_fail++; $display("FAIL pipe_read_return: prv=%b drv=%b want 1 0", pipe_rvalid, dma_rvalid);
        end
      end
      commit();
      idle_inputs();
    end
  endtask

  task automatic test_dma_write();
    idle_inputs(); dma_req = 1; dma_we = 4'hF; dma_addr = 32'h200; dma_wdata = $urandom;
    for (int c = 0; c < 4; c++) begin
      predict();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL dma_write_model c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (c == 0) begin
        n_checks++;
        if (dma_gnt !== 1'b1 || mem_we !== 4'hF || pipe_stall !== 1'b0 || mem_addr !== 32'h200) begin
          n_fail++; $display("FAIL dma_write_grant: gnt=%b we=%h stall=%b addr=%h want 1 F 0 200",
                             dma_gnt, mem_we, pipe_stall, mem_addr);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (pipe_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
          n_fail++; $display("FAIL dma_write_no_rvalid: prv=%b drv=%b want 0 0", pipe_rvalid, dma_rvalid);
        end
      end
      commit();
      idle_inputs();
    end
  endtask

  task automatic test_starvation();
    int grant_at = 0;
    int stalls   = 0;
    idle_inputs();
    pipe_re = 1; pipe_addr = 32'h400; dma_req = 1; dma_addr = 32'h300;
    for (int c = 1; c <= 20 && grant_at == 0; c++) begin
      predict();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL starve_model c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (pipe_stall === 1'b1) stalls++;
      if (dma_gnt === 1'b1) grant_at = c;
      commit();
    end
    dma_req = 0;
    n_checks++;
    if (grant_at != STARVE_LIMIT + 1 || stalls != 1) begin
      n_fail++; $display("FAIL starve_grant: grant cycle %0d stalls %0d want %0d 1",
                         grant_at, stalls, STARVE_LIMIT + 1);
    end
    for (int c = 1; c <= 4; c++) begin
      predict();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL starve_after_model c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (c == MEM_LAT) begin
        n_checks++;
        if (dma_rvalid !== 1'b1 || pipe_rvalid !== 1'b0) begin
          n_fail++; $display("FAIL starve_return: drv=%b prv=%b want 1 0", dma_rvalid, pipe_rvalid);
        end
      end
      commit();
      if (c == 2) pipe_re = 0;
    end
  endtask

  task automatic test_halt();
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      pipe_re   = (c <= 3) && (c != 3);
      pipe_addr = 32'h10 + 32'(4 * c);
      halt      = (c >= 2) && (c <= 8);
      dma_req   = (c >= 5) && (c <= 8);
      dma_we    = (c == 6) ? 4'h3 : 4'h0;
      dma_addr  = 32'h600 + 32'(c);
      predict();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL halt_model c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (c == 2) begin
        n_checks++;
        if (mem_re !== 1'b0 || pipe_stall !== 1'b0 || pipe_rvalid !== 1'b1) begin
          n_fail++; $display("FAIL halt_entry: re=%b stall=%b prv=%b want 0 0 1", mem_re, pipe_stall, pipe_rvalid);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (pipe_rvalid !== 1'b1 || halted !== 1'b0) begin
          n_fail++; $display("FAIL halt_drain: prv=%b halted=%b want 1 0", pipe_rvalid, halted);
        end
      end
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if (halted !== 1'b1 || dma_gnt !== (c >= 5) || pipe_stall !== 1'b0) begin
          n_fail++; $display("FAIL halt_owned c%0d: halted=%b gnt=%b stall=%b", c, halted, dma_gnt, pipe_stall);
        end
      end
      commit();
    end
    idle_inputs();
  endtask

  task automatic test_clk_en();
    idle_inputs(); pipe_re = 1; pipe_addr = 32'h20;
    for (int c = 0; c < 7; c++) begin
      clk_en  = !(c >= 1 && c <= 3);
      pipe_re = (c <= 3);
      predict();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL clk_en_model c%0d: got %h want %h", c, obs_v, exp_v);
      end
      if (c >= 1) begin
        n_checks++;
        if (pipe_rvalid !== (c == 5) || (c <= 3 && mem_re !== 1'b0)) begin
          n_fail++; $display("FAIL clk_en_return c%0d: prv=%b re=%b want prv=%b re=0",
                             c, pipe_rvalid, mem_re, (c == 5));
        end
      end
      commit();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs(); dma_req = 1; dma_addr = 32'h500;
    predict();
    n_checks++;
    if (dma_gnt !== 1'b1 || mem_re !== 1'b1 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL rst_mid_grant: got %h want %h", obs_v, exp_v);
    end
    commit();
    idle_inputs();
    rst_n = 0; pipe_re = 1; pipe_addr = 32'h44;
    predict();
    n_checks++;
    if (obs_v !== 74'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", obs_v);
    end
    commit();
    rst_n = 1; pipe_re = 0;
    for (int c = 0; c < 3; c++) begin
      predict();
      n_checks++;
      if (dma_rvalid !== 1'b0 || obs_v !== exp_v) begin
        n_fail++; $display("FAIL rst_mid_discard c%0d: got %h want %h", c, obs_v, exp_v);
      end
      commit();
    end
  endtask

  task automatic test_random();
    bit last_gnt = 1'b1;
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 99) < 2) halt = !halt;
      clk_en     = ($urandom_range(0, 9) != 0);
      pipe_re    = ($urandom_range(0, 9) < 6);
      pipe_we    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      pipe_addr  = $urandom;
      pipe_wdata = $urandom;
      if (!dma_req || last_gnt) begin
        dma_req   = ($urandom_range(0, 2) == 0);
        dma_we    = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        dma_addr  = $urandom;
        dma_wdata = $urandom;
      end
      predict();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL random_model c%0d: got %h want %h", c, obs_v, exp_v);
      end
      last_gnt = (dma_gnt === 1'b1) || !rst_n;
      commit();
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipe_read();
    test_dma_write();
    test_starvation();
    test_halt();
    test_clk_en();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the pipeline's memory access (driven from the execute→memory_a register stage) and one secondary single-beat requester (DMA/debug). It returns read data to the correct owner after the fixed memory latency. It also guarantees the secondary requester a slot within a bounded wait by stalling the pipeline. On `halt` it drains in-flight reads and hands the port to the secondary requester exclusively.

## Interface
- `MEM_LAT`, 2: memory read latency in cycles, from request to `mem_rdata` valid; legal range 1..4.
- `STARVE_LIMIT`, 8: maximum cycles a pending secondary request waits before it steals a slot; must be ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `clk_en` in 1: global clock enable; when low, all state holds.
- `halt` in 1: pipeline halt request.
- `pipe_re` in 1: pipeline read request (already bubble-qualified).
- `pipe_we` in 4: pipeline byte write enables.
- `pipe_addr` in 32: pipeline address.
- `pipe_wdata` in 32: pipeline store data.
- `pipe_stall` out 1: pipeline must hold its request this cycle.
- `pipe_rvalid` out 1: `mem_rdata` belongs to the pipeline this cycle.
- `dma_req` in 1: secondary request valid; held with its payload until granted.
- `dma_we` in 4: secondary byte write enables; 0 means read.
- `dma_addr` in 32: secondary address.
- `dma_wdata` in 32: secondary write data.
- `dma_gnt` out 1: request accepted this cycle.
- `dma_rvalid` out 1: `mem_rdata` belongs to the secondary requester.
- `mem_re` out 1: memory read strobe.
- `mem_we` out 4: memory byte write enables.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; passed through unchanged to both owners.
- `halted` out 1: port drained; arbiter is in S_HALT.

## Operation
- States:
  - S_RUN: normal arbitration.
  - S_DRAIN: halt seen; waiting for in-flight reads to return.
  - S_HALT: secondary requester owns the port.
- Signal definitions:
  - `pipe_act = pipe_re | (|pipe_we)`.
  - `dma_sel`: the secondary requester is selected this cycle.
- S_RUN arbitration, evaluated combinationally each cycle:
  - `dma_sel = dma_req & (!pipe_act | starve_cnt == STARVE_LIMIT)`.
  - `pipe_stall = pipe_act & dma_sel`.
  - `dma_gnt = dma_sel & clk_en`.
  - Port mux selects the DMA payload when `dma_sel`, otherwise the pipeline payload.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`):
  - Clears on a DMA grant or when `dma_req` is low.
  - Otherwise increments while `dma_req & pipe_act`.
  - Saturates at STARVE_LIMIT.
- Return tag: MEM_LAT-deep shift register of {valid, owner}.
  - Entry 0 is loaded with `{mem_re, dma_sel}` each enabled cycle.
  - At the tail, `pipe_rvalid = valid & !owner` and `dma_rvalid = valid & owner`.
- Transitions:
  - S_RUN→S_DRAIN when `halt`. In that same cycle the pipeline request is suppressed: `mem_*` carries only the DMA payload, and the DMA is granted if `dma_req`. `pipe_stall` is 0.
  - S_DRAIN→S_HALT when the tag shift register holds no valid entries. No new grants are issued in S_DRAIN.
  - S_HALT: `dma_gnt = dma_req & clk_en` every cycle and pipeline inputs are ignored. Returns to S_RUN when `halt` is low.
- `halted` = 1 in S_HALT only.
- When `clk_en` = 0:
  - `mem_re`, `mem_we`, `dma_gnt` and `pipe_stall` are forced to 0.
  - Tag register, counter and state hold.
  - The tail `rvalid` outputs still reflect the held tag.

## Timing
- Reset values:
  - State S_RUN, `starve_cnt` 0, tag register all invalid.
  - All outputs 0, including `mem_*`, `dma_gnt`, `pipe_stall`, both `rvalid`s and `halted`.
- Grant and port drive are combinational, with zero-cycle latency from request to `mem_*`.
- Read data: a read issued in enabled cycle N returns in enabled cycle N+MEM_LAT with exactly one `rvalid` set.
- Writes produce no `rvalid`.
- Simultaneous events:
  - `dma_req` with no `pipe_act`: DMA is granted and the counter does not increment.
  - Counter at limit with `pipe_act`: DMA is granted, the pipeline stalls exactly one cycle, and the counter clears.
- Reset asserted mid-operation clears the in-flight tags. Returns in flight are discarded and no `rvalid` pulses after reset.
- Drain duration is ≤ MEM_LAT cycles.

## Structure
- Shared package `dmem_pkg`:
  - State enum `arb_state_t` (S_RUN, S_DRAIN, S_HALT).
  - Owner constants `OWN_PIPE` = 0 and `OWN_DMA` = 1.
- One sub-module, `dmem_ret_tag`: a parameterised MEM_LAT-deep {valid, owner} shift register with clock enable, async active-low reset and an `any_valid` output.

## Test plan
- Pipeline read at 0x100 only → `mem_re`=1 with `mem_addr`=0x100 in the same cycle; `pipe_rvalid` 2 cycles later; `dma_rvalid` stays 0.
- `dma_req` with `dma_we`=4'hF at 0x200 while `pipe_act`=0 → `dma_gnt`=1 and `mem_we`=4'hF in the same cycle; no stall.
- `pipe_act` held continuously and `dma_req` read held → DMA granted on the 9th cycle of its wait; `pipe_stall`=1 for exactly that cycle; `dma_rvalid` 2 cycles later.
- Pipeline reads in cycles 0 and 1, then `halt` in cycle 2 → no pipeline access in cycle 2; `pipe_rvalid` in cycles 2 and 3; `halted`=1 from cycle 4; DMA then granted every cycle until `halt` drops.
- `clk_en` low for 3 cycles between a read issue and its return → `rvalid` is delayed by exactly 3 cycles.
- `rst_n` pulsed low one cycle after a DMA read grant → no `dma_rvalid`; all outputs 0 during reset.
